vga_fill_arb: RTL

- Write-port controller in front of the VGA pixel memory, in the i_clk (memory-writing) domain.
- Shares the single pixel write port between CPU pixel stores and a hardware rectangle-fill engine that paints a solid 12-bit colour over an (X0,Y0)-(X1,Y1) region.
- The CPU has priority, but a starvation bound guarantees fill progress.
- Outputs feed the pixel address/data/write inputs of the VGA memory.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_fill_arb_if.sv | 55 +++++
 rtl/vga_rect_walker.sv | 87 ++++++++
 rtl/vga_fill_arb.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pixel write-port controller.
//   VGA_WIDTH / VGA_HEIGHT : logical framebuffer size (640x480 divided by 4)
//   fill_state_e           : fill controller states
//   fill_cmd_t             : rectangle fill command (inclusive bounds + colour)
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int VGA_WIDTH  = 160;
    localparam int VGA_HEIGHT = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    typedef struct packed {
        logic [7:0]  x0;
        logic [7:0]  x1;
        logic [7:0]  y0;
        logic [7:0]  y1;
        logic [11:0] color;
    } fill_cmd_t;

endpackage

// File: rtl/vga_fill_arb_if.sv
// ---------------------------------------------------------------------------
// vga_fill_arb_if
// Bundles every non-clock signal of vga_fill_arb.
//   CPU port  : i_cpuWr, i_cpuAddr, i_cpuData -> o_cpuReady
//   Fill cmd  : i_cmdValid, i_cmdX0/X1/Y0/Y1, i_cmdColor -> o_cmdReady
//   Control   : i_abort, i_irqAck
//   Pixel mem : o_pxlWr, o_pxlAddr, o_pxlData
//   Status    : o_busy, o_done, o_irq, o_dbgState (FSM state for observation)
// Handshakes: the CPU write is taken in any cycle where i_cpuWr & o_cpuReady;
// a fill command is taken in any cycle where i_cmdValid & o_cmdReady. A
// requester holds its request until it sees the matching ready.
// modport master : drives the requests (CPU / command source)
// modport slave  : the controller itself
// ---------------------------------------------------------------------------
interface vga_fill_arb_if;
    import vga_pkg::*;

    logic        i_cpuWr;
    logic [31:0] i_cpuAddr;
    logic [31:0] i_cpuData;
    logic        o_cpuReady;
    logic        i_cmdValid;
    logic        o_cmdReady;
    logic [7:0]  i_cmdX0;
    logic [7:0]  i_cmdX1;
    logic [7:0]  i_cmdY0;
    logic [7:0]  i_cmdY1;
    logic [11:0] i_cmdColor;
    logic        i_abort;
    logic        o_pxlWr;
    logic [31:0] o_pxlAddr;
    logic [31:0] o_pxlData;
    logic        o_busy;
    logic        o_done;
    logic        o_irq;
    logic        i_irqAck;
    fill_state_e o_dbgState;

    modport master (
        output i_cpuWr, i_cpuAddr, i_cpuData, i_cmdValid,
               i_cmdX0, i_cmdX1, i_cmdY0, i_cmdY1, i_cmdColor,
               i_abort, i_irqAck,
        input  o_cpuReady, o_cmdReady, o_pxlWr, o_pxlAddr, o_pxlData,
               o_busy, o_done, o_irq, o_dbgState
    );

    modport slave (
        input  i_cpuWr, i_cpuAddr, i_cpuData, i_cmdValid,
               i_cmdX0, i_cmdX1, i_cmdY0, i_cmdY1, i_cmdColor,
               i_abort, i_irqAck,
        output o_cpuReady, o_cmdReady, o_pxlWr, o_pxlAddr, o_pxlData,
               o_busy, o_done, o_irq, o_dbgState
    );

endinterface

// File: rtl/vga_rect_walker.sv
// ---------------------------------------------------------------------------
// vga_rect_walker
// Raster cursor for the rectangle fill. On i_load it clamps the far corner
// to the screen, latches the bounds and parks the cursor at (x0,y0); on
// i_step it moves one pixel along the line, wrapping to the next line.
//   i_clk, i_reset        : clock, async active-high reset
//   i_load                : latch bounds from i_x0/i_x1/i_y0/i_y1
//   i_step                : advance cursor by one pixel
//   i_x0..i_y1            : raw command bounds (inclusive)
//   o_x, o_y              : current cursor
//   o_last                : cursor sits on the final pixel (x1,y1)
//   o_empty               : raw command bounds give an empty rectangle
// ---------------------------------------------------------------------------
module vga_rect_walker #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [7:0] i_x0,
    input  logic [7:0] i_x1,
    input  logic [7:0] i_y0,
    input  logic [7:0] i_y1,
    output logic [7:0] o_x,
    output logic [7:0] o_y,
    output logic       o_last,
    output logic       o_empty
);

    localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
    localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);

    logic [7:0] x1_clamp;
    logic [7:0] y1_clamp;
    logic [7:0] x_q, x_d, y_q, y_d;
    logic [7:0] x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;

    assign x1_clamp = (i_x1 > X_MAX) ? X_MAX : i_x1;
    assign y1_clamp = (i_y1 > Y_MAX) ? Y_MAX : i_y1;
    // Evaluated on the raw inputs so the controller can skip FILL on accept.
    assign o_empty  = (x1_clamp < i_x0) || (y1_clamp < i_y0);

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        x0_d = x0_q;
        x1_d = x1_q;
        y1_d = y1_q;
        if (i_load) begin
            x_d  = i_x0;
            y_d  = i_y0;
            x0_d = i_x0;
            x1_d = x1_clamp;
            y1_d = y1_clamp;
        end else if (i_step) begin
            if (x_q == x1_q) begin
                x_d = x0_q;
                y_d = y_q + 8'd1;
            end else begin
                x_d = x_q + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            x_q  <= '0;
            y_q  <= '0;
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            x0_q <= x0_d;
            x1_q <= x1_d;
            y1_q <= y1_d;
        end
    end

    assign o_x    = x_q;
    assign o_y    = y_q;
    assign o_last = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/vga_fill_arb.sv
// ---------------------------------------------------------------------------
// vga_fill_arb
// Owns the single VGA pixel-memory write port and shares it between CPU
// pixel stores and a rectangle-fill engine. The CPU has priority, but after
// MAX_STALL consecutive stolen fill cycles the fill gets one forced slot.
// All pixel-port outputs are registered (one cycle after the grant).
//   i_clk, i_reset : clock, async active-high reset
//   bus (slave)    : CPU port, fill command, abort, pixel port, status, irq
// Optional: define VGA_FILL_IRQ_EN to get a sticky o_irq completion flag
// cleared by i_irqAck; otherwise o_irq is 0 and i_irqAck is ignored.
// ---------------------------------------------------------------------------
module vga_fill_arb
    import vga_pkg::*;
#(
    parameter int WIDTH     = VGA_WIDTH,
    parameter int HEIGHT    = VGA_HEIGHT,
    parameter int MAX_STALL = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    vga_fill_arb_if.slave bus
);

    localparam int SW = $clog2(MAX_STALL + 1);

    fill_state_e state_q, state_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [11:0]   color_q, color_d;
    logic          pxl_wr_q, pxl_wr_d;
    logic [31:0]   pxl_addr_q, pxl_addr_d;
    logic [31:0]   pxl_data_q, pxl_data_d;
    logic          done_q;

    logic       accept;
    logic       in_fill;
    logic       stall_max;
    logic       cpu_ready;
    logic       cpu_grant;
    logic       fill_grant;
    logic [7:0] walk_x, walk_y;
    logic       walk_last, walk_empty;
    logic [15:0] fill_addr;

    vga_rect_walker #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_walker (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (accept),
        .i_step  (fill_grant),
        .i_x0    (bus.i_cmdX0),
        .i_x1    (bus.i_cmdX1),
        .i_y0    (bus.i_cmdY0),
        .i_y1    (bus.i_cmdY1),
        .o_x     (walk_x),
        .o_y     (walk_y),
        .o_last  (walk_last),
        .o_empty (walk_empty)
    );

    assign accept    = bus.i_cmdValid && (state_q == IDLE);
    assign in_fill   = (state_q == FILL);
    assign stall_max = (stall_q == SW'(MAX_STALL));
    // Only the forced fill slot ever refuses the CPU.
    assign cpu_ready = !(in_fill && bus.i_cpuWr && stall_max);
    assign cpu_grant = bus.i_cpuWr && cpu_ready;
    // Fill wins when the CPU is quiet or has used up its stall allowance;
    // an abort cycle never writes a fill pixel.
    assign fill_grant = in_fill && !bus.i_abort && !(bus.i_cpuWr && !stall_max);
    assign fill_addr  = 16'(walk_y) * 16'(WIDTH) + 16'(walk_x);

    always_comb begin
        state_d    = state_q;
        stall_d    = '0;
        color_d    = color_q;
        pxl_wr_d   = 1'b0;
        pxl_addr_d = pxl_addr_q;
        pxl_data_d = pxl_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    color_d = bus.i_cmdColor;
                    state_d = walk_empty ? DONE : FILL;
                end
            end
            FILL: begin
                if (bus.i_abort) begin
                    state_d = IDLE;
                end else if (fill_grant) begin
                    if (walk_last) begin
                        state_d = DONE;
                    end
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cpu_grant) begin
            pxl_wr_d   = 1'b1;
            pxl_addr_d = bus.i_cpuAddr;
            pxl_data_d = bus.i_cpuData;
        end else if (fill_grant) begin
            pxl_wr_d   = 1'b1;
            pxl_addr_d = {16'b0, fill_addr};
            pxl_data_d = {20'b0, color_q};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            stall_q    <= '0;
            color_q    <= '0;
            pxl_wr_q   <= 1'b0;
            pxl_addr_q <= '0;
            pxl_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            color_q    <= color_d;
            pxl_wr_q   <= pxl_wr_d;
            pxl_addr_q <= pxl_addr_d;
            pxl_data_q <= pxl_data_d;
            // Registered like the pixel port, so the pulse follows the last write.
            done_q     <= (state_q == DONE);
        end
    end

`ifdef VGA_FILL_IRQ_EN
    logic irq_q;

    // Set covers both the DONE cycle and the visible o_done cycle, so an ack
    // arriving together with a fresh completion cannot clear it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (state_q == DONE) || done_q || (irq_q && !bus.i_irqAck);
        end
    end

    assign bus.o_irq = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = bus.i_irqAck;
    assign bus.o_irq      = 1'b0;
`endif

    assign bus.o_cpuReady = cpu_ready;
    assign bus.o_cmdReady = (state_q == IDLE);
    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_done     = done_q;
    assign bus.o_pxlWr    = pxl_wr_q;
    assign bus.o_pxlAddr  = pxl_addr_q;
    assign bus.o_pxlData  = pxl_data_q;
    assign bus.o_dbgState = state_q;

endmodule
